// File: rtl/uart_rx_parity_if.sv
// uart_rx_parity_if: serial-side and result-side signals of the UART receiver.
//   b_tick        1-clk pulse at 16x baud (from the shared baud generator)
//   Rx_d_in       serial line, idle high
//   PARITYSEL_Rx  0 = even parity, 1 = odd parity
//   Rx_done       1-clk pulse when a frame has completed
//   Rx_d_out      [DBIT-1:0] received data, [DBIT] parity-error flag
//   Rx_ferr       framing error (stop bit sampled 0), valid with Rx_done
//   ERRCOUNTER    saturating count of errored frames
// master = whoever drives the line/tick (bench or link), slave = the receiver.
interface uart_rx_parity_if #(
    parameter int DBIT  = 8,
    parameter int CNT_W = 16
);
    logic             b_tick;
    logic             Rx_d_in;
    logic             PARITYSEL_Rx;
    logic             Rx_done;
    logic [DBIT:0]    Rx_d_out;
    logic             Rx_ferr;
    logic [CNT_W-1:0] ERRCOUNTER;

    modport master (
        output b_tick, Rx_d_in, PARITYSEL_Rx,
        input  Rx_done, Rx_d_out, Rx_ferr, ERRCOUNTER
    );

    modport slave (
        input  b_tick, Rx_d_in, PARITYSEL_Rx,
        output Rx_done, Rx_d_out, Rx_ferr, ERRCOUNTER
    );
endinterface

// File: rtl/uart_rx_parity.sv
// uart_rx_parity: UART receiver for start + DBIT data (LSB first) + parity + stop
// frames, sampled with a 16x oversampling tick.
//   clk    system clock
//   reset  asynchronous, active-high
//   rx     uart_rx_parity_if.slave (tick, serial line, parity select in;
//          done pulse, data+parity flag, framing error, error counter out)
// The interface instance must be built with the same DBIT/CNT_W as this module.
module uart_rx_parity #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_parity_if.slave rx
);
    // Tick counter must reach both 15 (data/parity) and SB_TICK-1 (stop).
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [DBIT-1:0]  data_q, data_d;
    logic             par_q, par_d;
    logic             psel_q, psel_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             done_q, done_d;
    logic [DBIT:0]    dout_q, dout_d;
    logic             ferr_q, ferr_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d;

    logic             line;
    logic             fall;
    logic             perr;
    logic [DBIT:0]    shift_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            n_q      <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            psel_q   <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            done_q   <= 1'b0;
            dout_q   <= '0;
            ferr_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            data_q   <= data_d;
            par_q    <= par_d;
            psel_q   <= psel_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        data_d   = data_q;
        par_d    = par_q;
        psel_d   = psel_q;
        done_d   = 1'b0;
        dout_d   = dout_q;
        ferr_d   = ferr_q;
        errcnt_d = errcnt_q;

        sync1_d  = rx.Rx_d_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;

        line     = sync2_q;
        // prev_q tracks the synced line in every state, so a line that is
        // already low on entry to IDLE produces no edge until it goes high.
        fall     = prev_q & ~sync2_q;
        perr     = ((^data_q) ^ par_q) != psel_q;
        shift_w  = {line, data_q};

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    s_d     = '0;
                    psel_d  = rx.PARITYSEL_Rx;
                    state_d = START;
                end
            end
            START: begin
                if (rx.b_tick) begin
                    if (s_q == S_W'(7)) begin
                        // Mid start bit: still low -> real frame, else glitch.
                        if (!line) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (rx.b_tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d    = '0;
                        data_d = shift_w[DBIT:1];
                        if (n_q == N_W'(DBIT - 1)) state_d = PARITY;
                        else                       n_d     = n_q + N_W'(1);
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            PARITY: begin
                if (rx.b_tick) begin
                    if (s_q == S_W'(15)) begin
                        par_d   = line;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (rx.b_tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        s_d     = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = {perr, data_q};
                        ferr_d  = ~line;
                        // One increment per errored frame, held at all-ones.
                        if ((perr || !line) && (errcnt_q != {CNT_W{1'b1}}))
                            errcnt_d = errcnt_q + CNT_W'(1);
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.Rx_done    = done_q;
    assign rx.Rx_d_out   = dout_q;
    assign rx.Rx_ferr    = ferr_q;
    assign rx.ERRCOUNTER = errcnt_q;
endmodule

// File: tb/tb_uart_rx_parity.sv
module tb_uart_rx_parity;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       psel = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] div = 2'd0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         done1 = 0;
    int         done2 = 0;
    int         exp_err = 0;

    always #5 clk = ~clk;

    // b_tick every 4 clocks.
    always @(posedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd3);
    end

    uart_rx_parity_if #(.DBIT(8), .CNT_W(16)) bus1 ();
    uart_rx_parity_if #(.DBIT(8), .CNT_W(2))  bus2 ();

    assign bus1.b_tick = tick;
    assign bus1.Rx_d_in = line;
    assign bus1.PARITYSEL_Rx = psel;
    assign bus2.b_tick = tick;
    assign bus2.Rx_d_in = line;
    assign bus2.PARITYSEL_Rx = psel;

    uart_rx_parity #(.DBIT(8), .SB_TICK(16), .CNT_W(16)) dut1 (
        .clk(clk), .reset(rst), .rx(bus1.slave));
    uart_rx_parity #(.DBIT(8), .SB_TICK(16), .CNT_W(2)) dut2 (
        .clk(clk), .reset(rst), .rx(bus2.slave));

    always @(negedge clk) begin
        if (bus1.Rx_done === 1'b1) done1++;
        if (bus2.Rx_done === 1'b1) done2++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        line = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (flip && i == 1) psel = ~psel;
        end
        send_bit(p);
        send_bit(stop);
    endtask

    typedef struct {
        logic       psel;
        logic [7:0] data;
        logic       p;
        logic       stop;
        logic       flip;
        logic [8:0] exp_dout;
        logic       exp_ferr;
        int         exp_inc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int b1, b2;
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 9'h0A5, 1'b0, 0};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 9'h13C, 1'b0, 1};
        vecs[2] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 0};
        vecs[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b1, 1};
        vecs[4] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 9'h101, 1'b1, 1};
        vecs[5] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 9'h080, 1'b0, 0};
        vecs[6] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 9'h155, 1'b0, 1};
        vecs[7] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 0};

        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus1.Rx_done), 32'd0);
        check("rst_dout", 32'(bus1.Rx_d_out), 32'd0);
        check("rst_ferr", 32'(bus1.Rx_ferr), 32'd0);
        check("rst_err", 32'(bus1.ERRCOUNTER), 32'd0);
        check("rst_err2", 32'(bus2.ERRCOUNTER), 32'd0);
        rst = 1'b0;
        wait_ticks(8);

        // Table-driven frames.
        for (int v = 0; v < 8; v++) begin
            psel = vecs[v].psel;
            b1 = done1;
            send_frame(vecs[v].data, vecs[v].p, vecs[v].stop, vecs[v].flip);
            line = 1'b1;
            wait_ticks(4);
            exp_err += vecs[v].exp_inc;
            check($sformatf("v%0d_done", v), 32'(done1 - b1), 32'd1);
            check($sformatf("v%0d_dout", v), 32'(bus1.Rx_d_out), 32'(vecs[v].exp_dout));
            check($sformatf("v%0d_ferr", v), 32'(bus1.Rx_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_err", v), 32'(bus1.ERRCOUNTER), 32'(exp_err));
        end
        psel = 1'b0;

        // Short low pulse is a glitch; a clean frame follows.
        b1 = done1;
        line = 1'b0;
        wait_ticks(4);
        line = 1'b1;
        wait_ticks(20);
        check("glitch_nodone", 32'(done1 - b1), 32'd0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        check("glitch_next_done", 32'(done1 - b1), 32'd1);
        check("glitch_next_dout", 32'(bus1.Rx_d_out), 32'h055);

        // Framing error, then line held low (break).
        b1 = done1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        wait_ticks(40);
        exp_err++;
        check("brk_done", 32'(done1 - b1), 32'd1);
        check("brk_ferr", 32'(bus1.Rx_ferr), 32'd1);
        check("brk_dout", 32'(bus1.Rx_d_out), 32'h081);
        check("brk_err", 32'(bus1.ERRCOUNTER), 32'(exp_err));
        wait_ticks(200);
        check("brk_hold", 32'(done1 - b1), 32'd1);
        line = 1'b1;
        wait_ticks(20);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        check("brk_next_done", 32'(done1 - b1), 32'd2);
        check("brk_next_dout", 32'(bus1.Rx_d_out), 32'h055);
        check("brk_next_ferr", 32'(bus1.Rx_ferr), 32'd0);

        // Reset in the middle of data bit 3.
        b1 = done1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        line = 1'b0;
        wait_ticks(8);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dout", 32'(bus1.Rx_d_out), 32'd0);
        check("mid_rst_ferr", 32'(bus1.Rx_ferr), 32'd0);
        check("mid_rst_err", 32'(bus1.ERRCOUNTER), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        line = 1'b1;
        exp_err = 0;
        wait_ticks(200);
        check("mid_rst_nodone", 32'(done1 - b1), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        wait_ticks(4);
        check("post_rst_done", 32'(done1 - b1), 32'd1);
        check("post_rst_dout", 32'(bus1.Rx_d_out), 32'h0F0);

        // Back-to-back parity-error frames; narrow counter saturates.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(8);
        b1 = done1;
        b2 = done2;
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
            check($sformatf("sat_err2_%0d", k), 32'(bus2.ERRCOUNTER), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            check($sformatf("sat_err1_%0d", k), 32'(bus1.ERRCOUNTER), 32'(k + 1));
        end
        wait_ticks(4);
        check("sat_done2", 32'(done2 - b2), 32'd5);
        check("sat_done1", 32'(done1 - b1), 32'd5);
        check("sat_dout2", 32'(bus2.Rx_d_out), 32'h13C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
